// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the tapped-delay-line TDC measurement path.
package tdc_pkg;

  localparam int N_DELAY_DEF = 32;
  localparam int SETTLE_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_SETTLE,
    ST_CAPTURE,
    ST_RECOVER,
    ST_DONE
  } tdc_state_e;

  // Tap count must represent 0..N inclusive, hence N+1 codes.
  function automatic int tdc_cw(input int n);
    return $clog2(n + 1);
  endfunction

  // Eight extra bits cover up to 255 accumulated samples.
  function automatic int tdc_sw(input int n);
    return tdc_cw(n) + 8;
  endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// Thermometer code to tap count, plus a flag for any set bit above the first zero.
module tdc_therm2bin
  import tdc_pkg::*;
#(
  parameter  int N_DELAY = N_DELAY_DEF,
  localparam int CW      = tdc_cw(N_DELAY)
) (
  input  logic [N_DELAY-1:0] code_i,
  output logic [CW-1:0]      count_o,
  output logic               bubble_o
);

  logic          run;
  logic [CW-1:0] count;
  logic          bubble;

  // 'run' stays high while every tap so far has fired; a set tap after it drops is a bubble.
  always_comb begin
    run    = 1'b1;
    count  = '0;
    bubble = 1'b0;
    for (int i = 0; i < N_DELAY; i++) begin
      run    = run & code_i[i];
      count  = count + CW'(run);
      bubble = bubble | (code_i[i] & ~run);
    end
  end

  assign count_o  = count;
  assign bubble_o = bubble;

endmodule

// File: rtl/tdc_measure_ctrl.sv
// Burst sequencer for the TDC delay line: launch/settle/capture per sample,
// accumulating sum/min/max of tap counts and handing the result off via valid/ready.
module tdc_measure_ctrl
  import tdc_pkg::*;
#(
  parameter  int N_DELAY = N_DELAY_DEF,
  localparam int CW      = tdc_cw(N_DELAY),
  localparam int SW      = tdc_sw(N_DELAY)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_req,
  input  logic [7:0]          cfg_num_samples,
  input  logic [SETTLE_W-1:0] cfg_settle,
  output logic                tdc_start,
  input  logic [N_DELAY-1:0]  tdc_code,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [SW-1:0]       result_sum,
  output logic [CW-1:0]       result_min,
  output logic [CW-1:0]       result_max,
  output logic                result_bubble
);

  tdc_state_e          state_q;
  logic [SETTLE_W-1:0] settle_cfg_q;
  logic [SETTLE_W-1:0] timer_q;
  logic [7:0]          samples_left_q;
  logic                tdc_start_q;
  logic                busy_q;
  logic                valid_q;
  logic [SW-1:0]       sum_q;
  logic [CW-1:0]       min_q;
  logic [CW-1:0]       max_q;
  logic                bubble_q;

  logic [CW-1:0]       tap_count;
  logic                tap_bubble;
  logic [SW-1:0]       sum_d;
  logic [CW-1:0]       min_d;
  logic [CW-1:0]       max_d;
  logic                bubble_d;

  tdc_therm2bin #(.N_DELAY(N_DELAY)) u_therm2bin (
    .code_i   (tdc_code),
    .count_o  (tap_count),
    .bubble_o (tap_bubble)
  );

  // Conversion feeds the accumulators directly so the capture cycle folds in the live code.
  always_comb begin
    sum_d    = sum_q + {{(SW-CW){1'b0}}, tap_count};
    min_d    = (tap_count < min_q) ? tap_count : min_q;
    max_d    = (tap_count > max_q) ? tap_count : max_q;
    bubble_d = bubble_q | tap_bubble;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q        <= ST_IDLE;
      settle_cfg_q   <= '0;
      timer_q        <= '0;
      samples_left_q <= '0;
      tdc_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      valid_q        <= 1'b0;
      sum_q          <= '0;
      min_q          <= '1;
      max_q          <= '0;
      bubble_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            settle_cfg_q   <= (cfg_settle == '0) ? SETTLE_W'(1) : cfg_settle;
            samples_left_q <= (cfg_num_samples == 8'd0) ? 8'd1 : cfg_num_samples;
            sum_q          <= '0;
            min_q          <= '1;
            max_q          <= '0;
            bubble_q       <= 1'b0;
            busy_q         <= 1'b1;
            tdc_start_q    <= 1'b1;
            state_q        <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          timer_q <= settle_cfg_q - SETTLE_W'(1);
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (timer_q == '0) begin
            tdc_start_q <= 1'b0;
            state_q     <= ST_CAPTURE;
          end else begin
            timer_q <= timer_q - SETTLE_W'(1);
          end
        end
        ST_CAPTURE: begin
          sum_q          <= sum_d;
          min_q          <= min_d;
          max_q          <= max_d;
          bubble_q       <= bubble_d;
          samples_left_q <= samples_left_q - 8'd1;
          timer_q        <= settle_cfg_q - SETTLE_W'(1);
          state_q        <= ST_RECOVER;
        end
        ST_RECOVER: begin
          if (timer_q != '0) begin
            timer_q <= timer_q - SETTLE_W'(1);
          end else if (samples_left_q != 8'd0) begin
            tdc_start_q <= 1'b1;
            state_q     <= ST_LAUNCH;
          end else begin
            valid_q <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // start_req is not looked at here, so a request coinciding with the handshake is dropped.
          if (result_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tdc_start     = tdc_start_q;
  assign busy          = busy_q;
  assign result_valid  = valid_q;
  assign result_sum    = sum_q;
  assign result_min    = min_q;
  assign result_max    = max_q;
  assign result_bubble = bubble_q;

endmodule

// File: doc/tdc_measure_ctrl.md
Name: tdc_measure_ctrl

Overview:
Measurement sequencer for the tapped-delay-line TDC.
- On a start request it runs a burst of cfg_num_samples launch/settle/capture cycles on the delay line.
- Each captured thermometer code is converted to a tap count and folded into a running sum, minimum and maximum.
- The burst result is presented to the readout logic over a valid/ready handshake.
- Sits between the host pins and the delay-line instance; replaces manual start/capture toggling.

Parameters:
N_DELAY, 32, number of delay taps (width of tdc_code)
CW, $clog2(N_DELAY+1) = 6, width of one converted tap count
SW, CW+8 = 14, width of accumulated sum (up to 255 samples of N_DELAY)
SETTLE_W, 4, width of settle/recover cycle counters

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-high
start_req  in  1  single-cycle pulse; begins a burst when idle
cfg_num_samples  in  8  samples per burst; 0 treated as 1; sampled at burst start
cfg_settle  in  SETTLE_W  cycles tdc_start held before capture and low before next launch; 0 treated as 1; sampled at burst start
tdc_start  out  1  launch edge into the delay line
tdc_code  in  N_DELAY  thermometer code from the delay line (bit0 = first tap)
busy  out  1  high from accepted start_req until result accepted
result_valid  out  1  burst result available
result_ready  in  1  consumer accepts result when valid&ready
result_sum  out  SW  sum of tap counts over the burst
result_min  out  CW  smallest tap count in the burst
result_max  out  CW  largest tap count in the burst
result_bubble  out  1  at least one sample was not a clean thermometer code

Behaviour:
- Reset (async, while rst_n=1):
  - state=IDLE
  - tdc_start, busy, result_valid, result_bubble = 0
  - result_sum = 0; result_min = {CW{1}}; result_max = 0
  - All counters = 0
- FSM states: IDLE, LAUNCH, SETTLE, CAPTURE, RECOVER, DONE.
- IDLE:
  - start_req=1 → latch cfg values (0→1), clear accumulators (sum=0, min=all-ones, max=0, bubble=0), go to LAUNCH; busy=1 from the next cycle.
  - start_req outside IDLE is ignored (no queuing).
- LAUNCH: drive tdc_start=1; load settle counter with cfg_settle-1; go to SETTLE.
- SETTLE:
  - tdc_start held 1.
  - Counter decrements each cycle; at 0 go to CAPTURE.
  - LAUNCH rising to CAPTURE is exactly cfg_settle+1 cycles.
- CAPTURE:
  - Register tdc_code.
  - Tap count = number of consecutive 1s from bit0.
  - Bubble = any 1 above the first 0 (tdc_code != (1<<count)-1).
  - Accumulation happens in this cycle:
    - sum += count; min = min(min,count); max = max(max,count); bubble |= flag.
    - All-ones code gives count=N_DELAY; all-zeros gives 0.
  - Drop tdc_start; decrement sample counter; go to RECOVER.
- RECOVER:
  - tdc_start=0 for cfg_settle cycles.
  - Then go to LAUNCH if samples remain, else DONE.
- DONE:
  - result_valid=1; outputs stable until valid&ready.
  - On the handshake: result_valid=0, busy=0 next cycle, go to IDLE.
- Sum never overflows: 255*32 = 8160 < 2^14.
- Reset mid-burst aborts immediately to reset values; no partial result is emitted.
- start_req in the same cycle as the DONE handshake is ignored; a new request needs IDLE.
- Tap-count conversion is purely combinational and must not add a register stage.

Decomposition:
- Shared package tdc_pkg: state enum; N_DELAY default; CW/SW width functions; SETTLE_W constant.
- Sub-module tdc_therm2bin: combinational thermometer→count plus bubble flag, parameterised by N_DELAY. Reused by later readout logic.

Test Plan:
- Reset then idle: rst_n=1 for 3 cycles, then 0 → tdc_start=0, busy=0, result_valid=0, result_min=6'h3F, result_sum=0.
- Single sample: cfg_num_samples=1, cfg_settle=3, tdc_code=32'h0000_00FF, pulse start_req → tdc_start high exactly 4 cycles; result_sum=8, min=max=8, bubble=0; valid held until ready.
- Burst of 4: codes 0x0F, 0xFF, 0x3F, 0x01 per capture (cfg_settle=2) → result_sum=19, min=1, max=8, bubble=0.
- Boundaries and bubble: codes 0xFFFF_FFFF then 0x0000_00F7, cfg_num_samples=2 → counts 32 and 3; sum=35, min=3, max=32, bubble=1.
- Zero config and backpressure: cfg_num_samples=0, cfg_settle=0 → one sample, one settle cycle. Hold result_ready=0 for 10 cycles → outputs stable, busy=1. A start_req during DONE is ignored.
- Abort: assert rst_n during SETTLE of sample 2 of 4 → tdc_start=0 immediately, no result_valid. A fresh burst after reset produces a correct result.
